// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Shared RV32 core definitions: load/store funct3 codes, LSU
//             FSM states and access-size helpers.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;

   // RV32I load/store width and sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size encoding
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Unsigned codes only exist for loads; every unlisted code is a word access.
   function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
      if (f3 == F3_B || (!we && f3 == F3_BU))
         return SZ_B;
      else if (f3 == F3_H || (!we && f3 == F3_HU))
         return SZ_H;
      else
         return SZ_W;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Selects the byte/halfword addressed within a read word and
//             sign- or zero-extends it according to funct3.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
   import core_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Lane select followed by extension
   always_comb begin
      sel_byte = rdata_i[{off_i, 3'b000} +: 8];
      sel_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   data_o = {24'h0, sel_byte};
         F3_H:    data_o = {{16{sel_half[15]}}, sel_half};
         F3_HU:   data_o = {16'h0, sel_half};
         default: data_o = rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : RV32 memory-access stage. Single-outstanding request/response
//             data bus, store lane alignment, load extraction/extension and
//             pipeline stall generation.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            mem_op_valid_in,
   input  logic            mem_we_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] addr_in,
   input  logic [XLEN-1:0] store_data_in,
   input  logic            flush_in,
   output logic            dbus_req_o,
   output logic            dbus_we_o,
   output logic [XLEN-1:0] dbus_addr_o,
   output logic [XLEN-1:0] dbus_wdata_o,
   output logic [3:0]      dbus_wstrb_o,
   input  logic            dbus_gnt_in,
   input  logic            dbus_rvalid_in,
   input  logic [XLEN-1:0] dbus_rdata_in,
   output logic [XLEN-1:0] load_output_o,
   output logic            lsu_busy_o,
   output logic            lsu_done_o,
   output logic            misaligned_o
);

   lsu_state_t      state_q;
   logic            req_q, we_q, done_q, mis_q, drop_q;
   logic [XLEN-1:0] addr_q, wdata_q, load_q;
   logic [3:0]      wstrb_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;

   logic [1:0]      acc_size;
   logic            acc_misaligned;
   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_wstrb;
   logic [XLEN-1:0] ld_aligned;

   // Decode the presented access and place store data on its byte lanes
   always_comb begin
      acc_size       = access_size(mem_we_in, funct3_in);
      acc_misaligned = is_misaligned(acc_size, addr_in[1:0]);
      st_wdata       = store_data_in;
      st_wstrb       = 4'b1111;
      case (acc_size)
         SZ_B: begin
            st_wdata = {4{store_data_in[7:0]}};
            st_wstrb = 4'b0001 << addr_in[1:0];
         end
         SZ_H: begin
            st_wdata = {2{store_data_in[15:0]}};
            st_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Stall is combinational so the issuing stage holds during the capture cycle
   always_comb begin
      lsu_busy_o = (state_q != IDLE) ||
                   (mem_op_valid_in && !acc_misaligned && !flush_in);
   end

   lsu_load_align u_load_align (
      .rdata_i  (dbus_rdata_in),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (ld_aligned)
   );

   // Access FSM with registered bus and status outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         mis_q    <= 1'b0;
         drop_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= 4'b0000;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         load_q   <= '0;
      end else begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // A flush in the presentation cycle cancels the op entirely
               if (mem_op_valid_in && !flush_in) begin
                  if (acc_misaligned) begin
                     mis_q <= 1'b1;
                  end else begin
                     addr_q   <= {addr_in[XLEN-1:2], 2'b00};
                     we_q     <= mem_we_in;
                     wdata_q  <= st_wdata;
                     wstrb_q  <= st_wstrb;
                     funct3_q <= funct3_in;
                     off_q    <= addr_in[1:0];
                     drop_q   <= 1'b0;
                     req_q    <= 1'b1;
                     state_q  <= REQ;
                  end
               end
            end
            REQ: begin
               // Grant takes priority over a simultaneous flush
               if (dbus_gnt_in) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     state_q <= RESP;
                  end
               end else if (flush_in) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RESP: begin
               // The bus response is always consumed; a flush only suppresses it
               if (dbus_rvalid_in) begin
                  if (!(drop_q || flush_in)) begin
                     load_q <= ld_aligned;
                     done_q <= 1'b1;
                  end
                  drop_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (flush_in) begin
                  drop_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dbus_req_o    = req_q;
   assign dbus_we_o     = we_q;
   assign dbus_addr_o   = addr_q;
   assign dbus_wdata_o  = wdata_q;
   assign dbus_wstrb_o  = wstrb_q;
   assign load_output_o = load_q;
   assign lsu_done_o    = done_q;
   assign misaligned_o  = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit with a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        mem_op_valid_in = 1'b0, mem_we_in = 1'b0, flush_in = 1'b0;
   logic [2:0]  funct3_in = 3'b000;
   logic [31:0] addr_in = '0, store_data_in = '0, dbus_rdata_in = '0;
   logic        dbus_gnt_in = 1'b0, dbus_rvalid_in = 1'b0;
   logic        dbus_req_o, dbus_we_o, lsu_busy_o, lsu_done_o, misaligned_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o, load_output_o;
   logic [3:0]  dbus_wstrb_o;

   load_store_unit #(.XLEN(32)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .mem_op_valid_in(mem_op_valid_in), .mem_we_in(mem_we_in),
      .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
      .flush_in(flush_in),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o),
      .dbus_gnt_in(dbus_gnt_in), .dbus_rvalid_in(dbus_rvalid_in),
      .dbus_rdata_in(dbus_rdata_in), .load_output_o(load_output_o),
      .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .misaligned_o(misaligned_o)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;

   // Expected outputs for the current cycle
   logic        e_req = 0, e_we = 0, e_done = 0, e_mis = 0, e_busy = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_load = '0;
   logic [3:0]  e_wstrb = '0;
   logic        chk_on = 1'b0;

   // Last bus request seen, for literal spot checks
   logic [31:0] last_addr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;
   logic        last_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_bytes(input logic we, input logic [2:0] f3);
      if (f3 == 3'b000 || (!we && f3 == 3'b100)) return 1;
      if (f3 == 3'b001 || (!we && f3 == 3'b101)) return 2;
      return 4;
   endfunction

   function automatic logic ref_misal(input logic [31:0] a, input logic [2:0] f3, input logic we);
      return (int'(a[1:0]) % acc_bytes(we, f3)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                            input logic [2:0] f3);
      logic [31:0] w;
      w = rd >> (8 * int'(a[1:0]));
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [2:0] f3);
      int n;
      n = acc_bytes(1'b1, f3);
      return 4'(((1 << n) - 1) << int'(a[1:0]));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [2:0] f3);
      int n;
      n = acc_bytes(1'b1, f3);
      if (n == 1) return sd[7:0] * 32'h0101_0101;
      if (n == 2) return sd[15:0] * 32'h0001_0001;
      return sd;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_in) begin
      if (chk_on) begin
         chk("req",  {31'b0, dbus_req_o},   {31'b0, e_req});
         chk("done", {31'b0, lsu_done_o},   {31'b0, e_done});
         chk("mis",  {31'b0, misaligned_o}, {31'b0, e_mis});
         chk("busy", {31'b0, lsu_busy_o},   {31'b0, e_busy});
         chk("load_output", load_output_o, e_load);
         if (e_req) begin
            chk("we",   {31'b0, dbus_we_o}, {31'b0, e_we});
            chk("addr", dbus_addr_o, e_addr);
            if (e_we) begin
               chk("wdata", dbus_wdata_o, e_wdata);
               chk("wstrb", {28'b0, dbus_wstrb_o}, {28'b0, e_wstrb});
            end
         end
      end
      if (dbus_req_o) begin
         last_addr  = dbus_addr_o;
         last_wdata = dbus_wdata_o;
         last_wstrb = dbus_wstrb_o;
         last_we    = dbus_we_o;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic fl,
                        input logic g, input logic rv, input logic [31:0] rd);
      mem_op_valid_in = v;  mem_we_in = we;  funct3_in = f3;  addr_in = a;
      store_data_in = sd;   flush_in = fl;   dbus_gnt_in = g;
      dbus_rvalid_in = rv;  dbus_rdata_in = rd;
   endtask

   task automatic idle_cycle();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
   endtask

   task automatic zero_outputs_chk(input string tag);
      chk({tag, "_req"},   {31'b0, dbus_req_o},   32'h0);
      chk({tag, "_we"},    {31'b0, dbus_we_o},    32'h0);
      chk({tag, "_addr"},  dbus_addr_o,           32'h0);
      chk({tag, "_wdata"}, dbus_wdata_o,          32'h0);
      chk({tag, "_wstrb"}, {28'b0, dbus_wstrb_o}, 32'h0);
      chk({tag, "_load"},  load_output_o,         32'h0);
      chk({tag, "_done"},  {31'b0, lsu_done_o},   32'h0);
      chk({tag, "_mis"},   {31'b0, misaligned_o}, 32'h0);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                          input int g, input int r);
      drive(1, 0, f3, a, 32'h0, 0, 0, 0, 32'h0);
      e_req = 0; e_done = 0; e_mis = 0; e_busy = 1;
      tick();
      for (int i = 0; i <= g; i++) begin
         drive(0, 0, 3'b000, 32'h0, 32'h0, 0, (i == g), 0, 32'h0);
         e_req = 1; e_we = 0; e_addr = {a[31:2], 2'b00}; e_busy = 1;
         tick();
      end
      for (int j = 0; j <= r; j++) begin
         drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, (j == r), rd);
         e_req = 0; e_busy = 1;
         tick();
      end
      idle_cycle();
      e_done = 1; e_load = ref_load(rd, a, f3); e_busy = 0;
      tick();
      idle_cycle();
      e_done = 0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] sd,
                           input int g, input logic fl_at_gnt);
      drive(1, 1, f3, a, sd, 0, 0, 0, 32'h0);
      e_req = 0; e_done = 0; e_mis = 0; e_busy = 1;
      tick();
      for (int i = 0; i <= g; i++) begin
         drive(0, 0, 3'b000, 32'h0, 32'h0, fl_at_gnt && (i == g), (i == g), 0, 32'h0);
         e_req = 1; e_we = 1; e_addr = {a[31:2], 2'b00};
         e_wdata = ref_wdata(sd, f3); e_wstrb = ref_strb(a, f3); e_busy = 1;
         tick();
      end
      idle_cycle();
      e_req = 0; e_done = 1; e_busy = 0;
      tick();
      idle_cycle();
      e_done = 0;
   endtask

   task automatic do_misal(input logic [31:0] a, input logic [2:0] f3, input logic we);
      drive(1, we, f3, a, 32'hFFFF_FFFF, 0, 0, 0, 32'h0);
      e_req = 0; e_done = 0; e_mis = 0; e_busy = !ref_misal(a, f3, we);
      tick();
      idle_cycle();
      e_mis = ref_misal(a, f3, we); e_busy = 0;
      tick();
      e_mis = 0;
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      idle_cycle();
      tick();
      tick();
      zero_outputs_chk("reset");
      chk("reset_busy", {31'b0, lsu_busy_o}, 32'h0);
      rst_n_in = 1'b1;
      chk_on = 1'b1;

      // LB sign extension
      do_load(32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 0);
      chk("lb_literal", load_output_o, 32'hFFFF_FF80);

      // LHU zero extension with bus stalls
      do_load(32'h0000_2002, 3'b101, 32'hBEEF_0000, 1, 2);
      chk("lhu_literal", load_output_o, 32'h0000_BEEF);
      chk("lhu_addr_literal", last_addr, 32'h0000_2000);

      // SB with grant held off three cycles
      do_store(32'h0000_3001, 3'b000, 32'h1234_56AB, 3, 0);
      chk("sb_wdata_literal", last_wdata, 32'hABAB_ABAB);
      chk("sb_wstrb_literal", {28'b0, last_wstrb}, 32'h0000_0002);
      chk("sb_we_literal", {31'b0, last_we}, 32'h0000_0001);

      // More widths; SW granted in the same cycle as a flush
      do_store(32'h0000_3002, 3'b001, 32'h0000_CAFE, 0, 0);
      do_store(32'h0000_3004, 3'b010, 32'h0102_0304, 1, 1);
      do_store(32'h0000_3008, 3'b111, 32'h5566_7788, 0, 0);
      do_load(32'h0000_1002, 3'b001, 32'h8001_0000, 0, 1);
      chk("lh_literal", load_output_o, 32'hFFFF_8001);
      do_load(32'h0000_1001, 3'b100, 32'h0000_F000, 0, 0);
      do_load(32'h0000_1000, 3'b010, 32'h89AB_CDEF, 2, 0);

      // Misaligned accesses
      do_misal(32'h0000_4002, 3'b010, 1);
      do_misal(32'h0000_4001, 3'b001, 0);
      do_misal(32'h0000_4003, 3'b101, 0);
      do_misal(32'h0000_4001, 3'b011, 0);

      // Flush in REQ before grant
      drive(1, 0, 3'b010, 32'h0000_6000, 32'h0, 0, 0, 0, 32'h0);
      e_req = 0; e_busy = 1;
      tick();
      idle_cycle();
      e_req = 1; e_we = 0; e_addr = 32'h0000_6000; e_busy = 1;
      tick();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 0, 32'h0);
      tick();
      idle_cycle();
      e_req = 0; e_busy = 0;
      tick();
      tick();

      // Flush in RESP, then response arrives
      drive(1, 0, 3'b010, 32'h0000_7000, 32'h0, 0, 0, 0, 32'h0);
      e_busy = 1;
      tick();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 0, 32'h0);
      e_req = 1; e_we = 0; e_addr = 32'h0000_7000;
      tick();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 0, 32'h0);
      e_req = 0;
      tick();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
      tick();
      idle_cycle();
      e_busy = 0;
      tick();
      chk("flush_resp_hold", load_output_o, 32'h89AB_CDEF);
      do_load(32'h0000_7004, 3'b001, 32'h1111_7FFF, 0, 0);

      // Valid and flush together in IDLE
      drive(1, 0, 3'b010, 32'h0000_8000, 32'h0, 1, 0, 0, 32'h0);
      e_busy = 0;
      tick();
      idle_cycle();
      tick();

      // Reset asserted while waiting in RESP
      drive(1, 0, 3'b010, 32'h0000_5000, 32'h0, 0, 0, 0, 32'h0);
      e_busy = 1;
      tick();
      drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 0, 32'h0);
      e_req = 1; e_we = 0; e_addr = 32'h0000_5000;
      tick();
      idle_cycle();
      chk_on = 1'b0;
      rst_n_in = 1'b0;
      #1;
      zero_outputs_chk("async_rst");
      chk("async_rst_busy", {31'b0, lsu_busy_o}, 32'h0);
      tick();
      rst_n_in = 1'b1;
      drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1, 32'h1234_5678);
      e_req = 0; e_done = 0; e_mis = 0; e_busy = 0; e_load = 32'h0;
      chk_on = 1'b1;
      tick();
      idle_cycle();
      tick();
      tick();
      chk_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the RV32 core; sits directly upstream of the write-back mux and produces its load-data operand.
- Takes the effective address from the immediate adder, the rs2 value and funct3.
- Drives a single-outstanding request/response data bus and aligns store data into byte lanes.
- Extracts and sign- or zero-extends load data, stalling the pipeline while an access is in flight.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk_in  input  1  core clock
- rst_n_in  input  1  asynchronous active-low reset
- mem_op_valid_in  input  1  a load or store is presented this cycle
- mem_we_in  input  1  1 = store, 0 = load; sampled with mem_op_valid_in
- funct3_in  input  3  RV32I width/sign code
- addr_in  input  32  effective byte address (immediate adder output)
- store_data_in  input  32  rs2 value
- flush_in  input  1  discard the current access (branch/trap)
- dbus_req_o  output  1  bus request
- dbus_we_o  output  1  bus write enable
- dbus_addr_o  output  32  word-aligned address, addr_in with bits [1:0] forced to 0
- dbus_wdata_o  output  32  lane-aligned store data
- dbus_wstrb_o  output  4  byte strobes
- dbus_gnt_in  input  1  bus accepts the request this cycle
- dbus_rvalid_in  input  1  read data valid
- dbus_rdata_in  input  32  read data word
- load_output_o  output  32  extended load result, to the write-back mux
- lsu_busy_o  output  1  pipeline stall
- lsu_done_o  output  1  one-cycle pulse when an access completes
- misaligned_o  output  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset, asynchronous and active-low:
  - FSM returns to IDLE.
  - dbus_req_o, dbus_we_o, lsu_done_o and misaligned_o are 0.
  - dbus_addr_o, dbus_wdata_o, dbus_wstrb_o and load_output_o are 0.
  - Reset asserted mid-access abandons the access immediately; a late rvalid after reset is ignored.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is executed as LW/SW.
- Misalignment is defined as:
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 00.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - If mem_op_valid_in and the access is misaligned: pulse misaligned_o the next cycle, issue no bus access, stay in IDLE.
  - If mem_op_valid_in and the access is aligned: register addr, we, strobes, wdata, funct3 and addr[1:0], then go to REQ.
  - With mem_op_valid_in and flush_in in the same cycle, flush wins and nothing is captured.
- REQ:
  - dbus_req_o = 1, with all bus outputs held stable until dbus_gnt_in.
  - On gnt with a store: go to IDLE and pulse lsu_done_o the next cycle.
  - On gnt with a load: go to RESP.
  - flush_in before gnt: drop req, go to IDLE, no done.
  - flush_in and gnt in the same cycle: the access counts as accepted (gnt wins).
- RESP:
  - Wait for dbus_rvalid_in.
  - Extract the byte or half selected by the captured addr[1:0], extend it per funct3 and register it into load_output_o.
  - Pulse lsu_done_o in the same cycle load_output_o updates, then go to IDLE.
  - A flush during RESP sets a drop flag: the response is still awaited, but load_output_o is not updated and done is not pulsed.
- Store alignment:
  - SB: data replicated ×4; strobe = 0001 shifted left by addr[1:0].
  - SH: data replicated ×2; strobe = 0011 at addr[1] = 0, 1100 at addr[1] = 1.
  - SW: strobe = 1111.
- lsu_busy_o = (state ≠ IDLE) OR (mem_op_valid_in AND aligned AND NOT flush_in). This is combinational so the issuing stage stalls in the capture cycle.
- load_output_o holds its last value between loads.
- Latency:
  - Minimum store (gnt in the first REQ cycle): done 2 cycles after mem_op_valid_in.
  - Minimum load (gnt and rvalid each in the earliest cycle): done 3 cycles after mem_op_valid_in.
- dbus_rvalid_in outside RESP is ignored.

Decomposition:
- Shared package core_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the lsu_state_t enum {IDLE, REQ, RESP}.
- One sub-module, lsu_load_align: purely combinational, taking rdata, addr[1:0] and funct3 and producing the extended 32-bit value.
- Store alignment and the FSM stay in the top level.

Test Plan:
- LB sign extension:
  - Stimulus: load, funct3 000, addr 0x1003; gnt immediately; rvalid next cycle with rdata 0x80FF_1234.
  - Required: load_output_o = 0xFFFF_FF80, done pulses once, busy drops afterwards.
- LHU zero extension:
  - Stimulus: load, funct3 101, addr 0x2002, rdata 0xBEEF_0000.
  - Required: load_output_o = 0x0000_BEEF; dbus_addr_o = 0x2000.
- SB lane alignment:
  - Stimulus: store, funct3 000, addr 0x3001, store_data 0x1234_56AB.
  - Required: wdata 0xABAB_ABAB, wstrb 0010, dbus_we_o = 1.
  - gnt held off 3 cycles: req and bus outputs stay stable, done pulses one cycle after gnt.
- Misaligned accesses:
  - Stimulus: SW to 0x4002, and LH to 0x4001.
  - Required: misaligned_o pulses, dbus_req_o is never asserted, no done.
- Flush:
  - Flush in REQ before gnt: req drops next cycle, no done.
  - Load flushed in RESP, then rvalid with 0xDEAD_BEEF: load_output_o unchanged, no done, FSM returns to IDLE.
- Reset mid-access:
  - Stimulus: rst_n_in asserted low in RESP.
  - Required: all outputs 0 asynchronously; after reset a stray rvalid produces no done.
